// File: rtl/my_sdr_pkg.sv
// Shared definitions for the SDR framing path: frame FSM states, the default
// header marker and a constant-width helper for sizing pointers.
package my_sdr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } frame_state_t;

   localparam logic [15:0] SYNC_DEFAULT = 16'hA55A;

   // Number of address bits needed to index 'value' entries.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/my_sc_fifo.sv
// Single-clock show-ahead FIFO. The head word is read combinationally from the
// storage at the registered read pointer, so a word written at one edge is
// visible on rdata right after that edge. A flush empties the FIFO and wins
// over any same-cycle read or write.
module my_sc_fifo
   import my_sdr_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   input  logic             flush
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = wr && !full && !flush;
   assign rd_ok = rd && !empty && !flush;
   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);
   assign rdata = mem[rd_ptr];

   // Storage array; no reset so it maps onto inferred RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally modulo DEPTH; occupancy tracks fill level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/my_frame_packer.sv
// Frame packer: buffers non-stallable DDC samples and emits frames of one
// header word {SYNC, drops-since-last-header} followed by FRAME_LEN samples.
// Samples arriving while the buffer is full are dropped and counted.
module my_frame_packer
   import my_sdr_pkg::*;
#(
   parameter int          DEPTH     = 512,
   parameter int          FRAME_LEN = 256,
   parameter logic [15:0] SYNC      = SYNC_DEFAULT
) (
   input  logic        csi_clk,
   input  logic        rsi_reset,
   input  logic [31:0] asi_in0_data,
   input  logic        asi_in0_valid,
   output logic [31:0] aso_out0_data,
   output logic        aso_out0_valid,
   input  logic        aso_out0_ready,
   input  logic        coe_enable,
   output logic [31:0] coe_drop_total
);

   localparam logic [15:0] LAST_WORD = 16'(FRAME_LEN - 1);

   frame_state_t state;
   frame_state_t state_next;
   logic [15:0]  word_cnt;
   logic [15:0]  drop_cnt;
   logic [31:0]  fifo_rdata;
   logic         fifo_empty;
   logic         fifo_full;
   logic         fifo_wr;
   logic         fifo_rd;
   logic         hdr_done;
   logic         drop;

   // Full is the pre-pop view, so a write colliding with a pop on a full
   // FIFO is still dropped.
   assign fifo_wr = coe_enable && asi_in0_valid && !fifo_full;
   assign drop    = coe_enable && asi_in0_valid && fifo_full;

   my_sc_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (csi_clk),
      .rst   (rsi_reset),
      .wr    (fifo_wr),
      .wdata (asi_in0_data),
      .rd    (fifo_rd),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .flush (!coe_enable)
   );

   // Frame state register.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and stream outputs; outputs depend only on state and FIFO head.
   always_comb begin
      state_next     = state;
      aso_out0_valid = 1'b0;
      aso_out0_data  = '0;
      fifo_rd        = 1'b0;
      hdr_done       = 1'b0;
      case (state)
         IDLE: begin
            state_next = HDR;
         end
         HDR: begin
            aso_out0_valid = 1'b1;
            aso_out0_data  = {SYNC, drop_cnt};
            if (aso_out0_ready) begin
               hdr_done   = 1'b1;
               state_next = DATA;
            end
         end
         DATA: begin
            aso_out0_valid = !fifo_empty;
            aso_out0_data  = fifo_rdata;
            if (aso_out0_ready && !fifo_empty) begin
               fifo_rd = 1'b1;
               if (word_cnt == LAST_WORD) begin
                  state_next = HDR;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (!coe_enable) begin
         state_next = IDLE;
      end
   end

   // Position of the next sample word within the current frame.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         word_cnt <= '0;
      end else if (hdr_done) begin
         word_cnt <= '0;
      end else if (fifo_rd) begin
         word_cnt <= word_cnt + 16'd1;
      end
   end

   // Per-frame drop count; a drop on the header edge belongs to the next frame.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         drop_cnt <= '0;
      end else if (!coe_enable) begin
         drop_cnt <= '0;
      end else if (hdr_done) begin
         drop_cnt <= drop ? 16'd1 : 16'd0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Lifetime saturating drop total, cleared only by reset.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         coe_drop_total <= '0;
      end else if (drop && (coe_drop_total != 32'hFFFF_FFFF)) begin
         coe_drop_total <= coe_drop_total + 32'd1;
      end
   end

endmodule

// File: tb/tb_my_frame_packer.sv
// Directed bench for my_frame_packer with a scoreboard queue of expected
// output words, using a small configuration (DEPTH=8, FRAME_LEN=4).
module tb_my_frame_packer;

   localparam int DEPTH     = 8;
   localparam int FRAME_LEN = 4;

   logic        csi_clk;
   logic        rsi_reset;
   logic [31:0] asi_in0_data;
   logic        asi_in0_valid;
   logic [31:0] aso_out0_data;
   logic        aso_out0_valid;
   logic        aso_out0_ready;
   logic        coe_enable;
   logic [31:0] coe_drop_total;

   logic [31:0] exp_q[$];
   int          checks = 0;
   int          passes = 0;

   my_frame_packer #(
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .csi_clk        (csi_clk),
      .rsi_reset      (rsi_reset),
      .asi_in0_data   (asi_in0_data),
      .asi_in0_valid  (asi_in0_valid),
      .aso_out0_data  (aso_out0_data),
      .aso_out0_valid (aso_out0_valid),
      .aso_out0_ready (aso_out0_ready),
      .coe_enable     (coe_enable),
      .coe_drop_total (coe_drop_total)
   );

   // 100 MHz clock.
   initial begin
      csi_clk = 1'b0;
      forever #5 csi_clk = ~csi_clk;
   end

   function automatic logic [31:0] hdr(input logic [15:0] n);
      return {16'hA55A, n};
   endfunction

   task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge csi_clk);
      #1;
   endtask

   // Scoreboard: every transfer pops the oldest expected word.
   always @(negedge csi_clk) begin
      if (!rsi_reset && aso_out0_valid && aso_out0_ready) begin
         check32("word_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check32("stream_word", aso_out0_data, exp_q.pop_front());
         end
      end
   end

   task automatic wait_drain(input int budget);
      int cyc;
      cyc = 0;
      aso_out0_ready = 1'b1;
      while (exp_q.size() != 0 && cyc < budget) begin
         tick();
         cyc++;
      end
      tick();
      check32("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic disable_run();
      coe_enable    = 1'b0;
      asi_in0_valid = 1'b0;
      tick();
      tick();
      check32("idle_valid", 32'(aso_out0_valid), 32'd0);
   endtask

   task automatic run_stream(input int n, input int gap, input bit rnd, input logic [31:0] base);
      exp_q.push_back(hdr(16'h0000));
      coe_enable     = 1'b1;
      aso_out0_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         tick();
         if (rnd) aso_out0_ready = 1'($urandom_range(0, 1));
         asi_in0_valid = 1'b1;
         asi_in0_data  = base + 32'(k);
         exp_q.push_back(base + 32'(k));
         if ((k + 1) % FRAME_LEN == 0) exp_q.push_back(hdr(16'h0000));
         for (int g = 1; g < gap; g++) begin
            tick();
            asi_in0_valid = 1'b0;
            if (rnd) aso_out0_ready = 1'($urandom_range(0, 1));
         end
      end
      tick();
      asi_in0_valid = 1'b0;
      wait_drain(400);
   endtask

   initial begin
      rsi_reset      = 1'b1;
      coe_enable     = 1'b0;
      asi_in0_valid  = 1'b0;
      asi_in0_data   = '0;
      aso_out0_ready = 1'b0;
      #1;
      check32("reset_valid", 32'(aso_out0_valid), 32'd0);
      check32("reset_data", aso_out0_data, 32'd0);
      check32("reset_drop_total", coe_drop_total, 32'd0);
      tick();
      tick();
      #2 rsi_reset = 1'b0;
      tick();

      // Basic frames: 300 samples, one per 6 cycles, ready held high.
      run_stream(300, 6, 1'b0, 32'h1000_0000);
      check32("basic_drops", coe_drop_total, 32'd0);
      disable_run();

      // Overflow: 12 back-to-back samples into an 8-deep FIFO with no ready.
      aso_out0_ready = 1'b0;
      exp_q.push_back(hdr(16'h0004));
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(32'h2000_0000 + 32'(k));
         if (k == 3) exp_q.push_back(hdr(16'h0000));
      end
      exp_q.push_back(hdr(16'h0000));
      coe_enable = 1'b1;
      for (int k = 0; k < 12; k++) begin
         asi_in0_valid = 1'b1;
         asi_in0_data  = 32'h2000_0000 + 32'(k);
         tick();
      end
      asi_in0_valid = 1'b0;
      check32("overflow_drop_total", coe_drop_total, 32'd4);
      wait_drain(50);
      disable_run();

      // Header transfer coinciding with a drop on a full FIFO.
      aso_out0_ready = 1'b0;
      exp_q.push_back(hdr(16'h0000));
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(32'h3000_0000 + 32'(k));
         if (k == 3) exp_q.push_back(hdr(16'h0001));
      end
      exp_q.push_back(hdr(16'h0000));
      coe_enable = 1'b1;
      for (int k = 0; k < 8; k++) begin
         asi_in0_valid = 1'b1;
         asi_in0_data  = 32'h3000_0000 + 32'(k);
         tick();
      end
      asi_in0_data   = 32'h3000_0008;
      aso_out0_ready = 1'b1;
      tick();
      asi_in0_valid = 1'b0;
      check32("collision_drop_total", coe_drop_total, 32'd5);
      wait_drain(50);
      disable_run();

      // Mid-frame disable: word 2 is the last delivered, word 3 is flushed.
      aso_out0_ready = 1'b0;
      exp_q.push_back(hdr(16'h0000));
      for (int k = 0; k < 3; k++) exp_q.push_back(32'h4000_0000 + 32'(k));
      coe_enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         asi_in0_valid = 1'b1;
         asi_in0_data  = 32'h4000_0000 + 32'(k);
         tick();
      end
      asi_in0_valid  = 1'b0;
      aso_out0_ready = 1'b1;
      tick();
      tick();
      tick();
      coe_enable = 1'b0;
      tick();
      check32("disable_valid_falls", 32'(aso_out0_valid), 32'd0);
      check32("disable_delivered", 32'(exp_q.size()), 32'd0);
      tick();
      tick();
      exp_q.push_back(hdr(16'h0000));
      coe_enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         asi_in0_valid = 1'b1;
         asi_in0_data  = 32'h4100_0000 + 32'(k);
         exp_q.push_back(32'h4100_0000 + 32'(k));
         tick();
         asi_in0_valid = 1'b0;
         tick();
      end
      exp_q.push_back(hdr(16'h0000));
      wait_drain(50);
      check32("reenable_drops", coe_drop_total, 32'd5);
      disable_run();

      // Random backpressure with a sustainable input rate.
      run_stream(100, 8, 1'b1, 32'h5000_0000);
      check32("backpressure_drops", coe_drop_total, 32'd5);
      disable_run();

      // Asynchronous reset while in DATA with a word presented.
      aso_out0_ready = 1'b0;
      exp_q.push_back(hdr(16'h0000));
      coe_enable = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         asi_in0_valid = 1'b1;
         asi_in0_data  = 32'h6000_0000 + 32'(k);
      end
      tick();
      asi_in0_valid  = 1'b0;
      aso_out0_ready = 1'b1;
      tick();
      aso_out0_ready = 1'b0;
      check32("pre_reset_valid", 32'(aso_out0_valid), 32'd1);
      #2 rsi_reset = 1'b1;
      #1;
      check32("async_reset_valid", 32'(aso_out0_valid), 32'd0);
      check32("async_reset_data", aso_out0_data, 32'd0);
      check32("async_reset_drop_total", coe_drop_total, 32'd0);
      coe_enable = 1'b0;
      #3 rsi_reset = 1'b0;
      tick();
      check32("post_reset_idle", 32'(aso_out0_valid), 32'd0);
      coe_enable = 1'b1;
      tick();
      check32("post_reset_hdr_valid", 32'(aso_out0_valid), 32'd1);
      check32("post_reset_hdr_data", aso_out0_data, hdr(16'h0000));
      check32("post_reset_drop_total", coe_drop_total, 32'd0);
      check32("final_queue", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/my_frame_packer.md
# my_frame_packer

Framing and buffering stage that sits directly upstream of the FX2LP sender. It accepts one 32-bit {Q,I} sample per valid strobe from the DDC. The DDC cannot be stalled, so samples are buffered in a FIFO. The block emits an Avalon-ST stream of frames, each a header word followed by FRAME_LEN sample words, which the sender consumes byte-wise. Samples that arrive while the buffer is full are dropped and counted, and the count is reported in the next header.

## Interface
- DEPTH, 512: FIFO depth in 32-bit words; power of two, at least 4.
- FRAME_LEN, 256: sample words per frame; range 1..65535.
- SYNC, 16'hA55A: header marker, placed in header bits [31:16].
- csi_clk  in  1: single clock; all logic on the rising edge.
- rsi_reset  in  1: asynchronous, active-high reset.
- asi_in0_data  in  32: sample word {Q[31:16], I[15:0]}.
- asi_in0_valid  in  1: sample strobe; no ready exists, so the source never stalls.
- aso_out0_data  out  32: frame word (header or sample).
- aso_out0_valid  out  1: output word available.
- aso_out0_ready  in  1: sink accepts; ready latency 0, so a transfer happens when valid & ready at a rising edge.
- coe_enable  in  1: run control from the host; low means flush and hold idle.
- coe_drop_total  out  32: saturating count of all dropped samples since reset.

## Operation
- State machine with three states: IDLE, HDR, DATA.
- IDLE:
  - aso_out0_valid = 0; the FIFO is held empty; the frame drop counter is held at 0.
  - Moves to HDR on the first edge where coe_enable = 1.
- HDR:
  - aso_out0_valid = 1 unconditionally.
  - aso_out0_data = {SYNC, drop_cnt[15:0]}.
  - On transfer: drop_cnt clears, the word counter clears, and the state moves to DATA.
- DATA:
  - aso_out0_valid = !fifo_empty; aso_out0_data = FIFO head (show-ahead).
  - Each transfer pops one word and increments the word counter.
  - The transfer of word FRAME_LEN-1 (counting from 0) returns the state to HDR.
- Input side, every edge while coe_enable = 1:
  - If asi_in0_valid and not full: the sample is written.
  - If asi_in0_valid and full: the sample is dropped, drop_cnt increments, and coe_drop_total increments.
  - "Full" is evaluated before any same-cycle pop; a write that coincides with a pop on a full FIFO is still dropped.
- Counter widths:
  - drop_cnt is 16 bits and saturates at 16'hFFFF.
  - coe_drop_total is 32 bits, saturates at all-ones, and is cleared only by reset.
- Header transfer and drop in the same cycle: the drop belongs to the next frame, so drop_cnt loads 1 rather than 0.
- coe_enable falling in any state, including mid-frame: the next state is IDLE, the FIFO is flushed, and drop_cnt clears.
  - A word transferred on that same edge counts as delivered.
  - The sink receives a truncated frame and resynchronises on SYNC.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, so full means occupancy == DEPTH.

## Timing
- Reset values:
  - State IDLE.
  - aso_out0_valid = 0.
  - aso_out0_data = 0.
  - coe_drop_total = 0.
  - FIFO empty, drop_cnt = 0.
- Input-to-output latency is 1 cycle: a sample written at edge N is visible on aso_out0_data, with valid, after edge N if the FIFO was empty and the state is DATA.
- aso_out0_data and aso_out0_valid are combinational from registered state and the FIFO head. They do not depend combinationally on aso_out0_ready.
- Back-to-back transfers run at one word per cycle, including HDR→DATA and DATA→HDR.
- Throughput overhead is 1 header word per FRAME_LEN samples.
- The downstream sender asserts ready at most once per 5 of its cycles. Sustained input rate must therefore stay below that; the drop logic covers any excess.

## Structure
- Shared package my_sdr_pkg holds:
  - the state enum (IDLE, HDR, DATA);
  - the default SYNC constant;
  - a clog2 helper function.
- Sub-module my_sc_fifo: a single-clock show-ahead FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: wr, wdata, rd, rdata, empty, full, flush, plus the same clock and asynchronous reset.
  - Storage is inferred RAM with a registered read address, so the head is available the cycle after a write.
- The top level holds the frame FSM, the word counter, and the drop counters.

## Test plan
- **Basic frame:** reset, enable=1, ready=1, 300 samples at 1 per 6 cycles, FRAME_LEN=4 → output is A55A0000, s0, s1, s2, s3, A55A0000, s4 and so on, in order, with no drops.
- **Overflow:** DEPTH=8, ready=0, 12 back-to-back samples, then ready=1 → the first header reads A55A0004 and carries samples 0..7; coe_drop_total = 4.
- **Header/drop collision:** FIFO full, and a sample arrives on the same edge as the header transfer → the header shows the prior count, and the next header shows 0001.
- **Mid-frame disable:** enable drops after word 2 of a frame → valid falls the next cycle. On re-enable the output starts with A55A0000 and contains no stale samples.
- **Backpressure:** random ready (50%) with a constant input rate below capacity → the output sequence exactly equals the input samples with a header every FRAME_LEN words, and zero drops.
- **Async reset mid-DATA:** reset is asserted between clock edges → valid goes to 0 immediately. After release the state is IDLE and coe_drop_total = 0.
